// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if
//   Board-facing signal bundle of the LED pattern engine.
//   sw    : slide switches, N_LEDS bits (asynchronous, quasi-static)
//   up    : raw push button, next mode
//   down  : raw push button, previous mode
//   LED   : registered LED drive, N_LEDS bits
//   mode  : current display mode (0 BINARY, 1 SCAN, 2 MIRROR, 3 BREATHE)
//   tick  : one-cycle pattern step strobe
//   master = board/stimulus side, slave = pattern engine.
interface led_pattern_gen_if #(
  parameter int N_LEDS = 16
);
  logic [N_LEDS-1:0] sw;
  logic              up;
  logic              down;
  logic [N_LEDS-1:0] LED;
  logic [1:0]        mode;
  logic              tick;

  modport master (output sw, up, down, input  LED, mode, tick);
  modport slave  (input  sw, up, down, output LED, mode, tick);
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Generic N-LED pattern engine: binary counter, bouncing scan, switch
//   mirror and PWM breathing of switch-selected LEDs. The debounced up/down
//   buttons step the mode; every mode change restarts the step divider and
//   clears the pattern state.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : led_pattern_gen_if.slave (sw, up, down in; LED, mode, tick out)

// Per-button synchroniser + debouncer. o_press pulses on the edge where the
// debounced level goes 0->1; releases produce nothing.
module led_pattern_gen_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
)(
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_press
);
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_accept;

  // The counter only ever counts a continuous run of sync != stable, so a
  // bounce back to the stable level restarts the qualification.
  assign w_diff   = r_sync[1] != r_stable;
  assign w_accept = w_diff && (r_cnt == CNT_LAST);
  assign o_press  = w_accept && r_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync   <= '0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt    <= '0;
        r_stable <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

module led_pattern_gen #(
  parameter int N_LEDS          = 16,
  parameter int TICK_DIV        = 10_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PWM_W           = 4
)(
  input  logic               clk,
  input  logic               reset,
  led_pattern_gen_if.slave   bus
);
  localparam int               DIV_W    = $clog2(TICK_DIV);
  localparam int               POS_W    = $clog2(N_LEDS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  typedef enum logic [1:0] {
    M_BINARY  = 2'd0,
    M_SCAN    = 2'd1,
    M_MIRROR  = 2'd2,
    M_BREATHE = 2'd3
  } mode_e;

  // State
  mode_e             r_mode;
  logic [DIV_W-1:0]  r_div;
  logic [N_LEDS-1:0] r_step;
  logic [POS_W-1:0]  r_pos;
  logic              r_dir;   // 0 = moving left (pos increasing)
  logic [PWM_W-1:0]  r_duty;
  logic              r_fall;  // 0 = duty rising
  logic [PWM_W-1:0]  r_pwm;
  logic [N_LEDS-1:0] r_led;

  // Next-state
  mode_e             w_mode_nxt;
  logic [DIV_W-1:0]  w_div_nxt;
  logic [N_LEDS-1:0] w_step_nxt;
  logic [POS_W-1:0]  w_pos_nxt;
  logic              w_dir_nxt;
  logic [PWM_W-1:0]  w_duty_nxt;
  logic              w_fall_nxt;
  logic [PWM_W-1:0]  w_pwm_nxt;
  logic [N_LEDS-1:0] w_led_nxt;

  logic [1:0]        w_press;   // [0] up, [1] down
  logic              w_tick;
  logic              w_mode_chg;

  led_pattern_gen_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn [1:0] (
    .clk     (clk),
    .reset   (reset),
    .i_raw   ({bus.down, bus.up}),
    .o_press (w_press)
  );

  assign w_tick     = (r_div == DIV_LAST);
  // Simultaneous up and down presses cancel: no step, no clear.
  assign w_mode_chg = w_press[0] ^ w_press[1];

  always_comb begin
    w_mode_nxt = r_mode;
    w_div_nxt  = r_div;
    w_step_nxt = r_step;
    w_pos_nxt  = r_pos;
    w_dir_nxt  = r_dir;
    w_duty_nxt = r_duty;
    w_fall_nxt = r_fall;
    w_pwm_nxt  = r_pwm + 1'b1;
    w_led_nxt  = '0;

    // LED is registered from the current state, so it trails the pattern
    // state by one edge.
    case (r_mode)
      M_BINARY:  w_led_nxt = r_step;
      M_SCAN:    w_led_nxt = N_LEDS'(1) << r_pos;
      M_MIRROR:  w_led_nxt = bus.sw;
      M_BREATHE: w_led_nxt = bus.sw & {N_LEDS{r_pwm < r_duty}};
      default:   w_led_nxt = '0;
    endcase

    if (w_mode_chg) begin
      w_mode_nxt = w_press[0] ? mode_e'(r_mode + 2'd1) : mode_e'(r_mode - 2'd1);
      w_div_nxt  = '0;
      w_step_nxt = '0;
      w_pos_nxt  = '0;
      w_dir_nxt  = 1'b0;
      w_duty_nxt = '0;
      w_fall_nxt = 1'b0;
    end else begin
      w_div_nxt = w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        case (r_mode)
          M_BINARY: w_step_nxt = r_step + 1'b1;
          M_SCAN: begin
            // Turning at an end jumps straight to the neighbour so each end
            // is lit for a single tick.
            if (!r_dir) begin
              if (r_pos == POS_LAST) begin
                w_dir_nxt = 1'b1;
                w_pos_nxt = POS_LAST - 1'b1;
              end else begin
                w_pos_nxt = r_pos + 1'b1;
              end
            end else begin
              if (r_pos == '0) begin
                w_dir_nxt = 1'b0;
                w_pos_nxt = POS_W'(1);
              end else begin
                w_pos_nxt = r_pos - 1'b1;
              end
            end
          end
          M_BREATHE: begin
            if (!r_fall) begin
              if (r_duty == DUTY_MAX) begin
                w_fall_nxt = 1'b1;
                w_duty_nxt = DUTY_MAX - 1'b1;
              end else begin
                w_duty_nxt = r_duty + 1'b1;
              end
            end else begin
              if (r_duty == '0) begin
                w_fall_nxt = 1'b0;
                w_duty_nxt = PWM_W'(1);
              end else begin
                w_duty_nxt = r_duty - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= M_BINARY;
      r_div  <= '0;
      r_step <= '0;
      r_pos  <= '0;
      r_dir  <= 1'b0;
      r_duty <= '0;
      r_fall <= 1'b0;
      r_pwm  <= '0;
      r_led  <= '0;
    end else begin
      r_mode <= w_mode_nxt;
      r_div  <= w_div_nxt;
      r_step <= w_step_nxt;
      r_pos  <= w_pos_nxt;
      r_dir  <= w_dir_nxt;
      r_duty <= w_duty_nxt;
      r_fall <= w_fall_nxt;
      r_pwm  <= w_pwm_nxt;
      r_led  <= w_led_nxt;
    end
  end

  assign bus.LED  = r_led;
  assign bus.mode = r_mode;
  assign bus.tick = w_tick;
endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;
  localparam int N    = 8;
  localparam int TD   = 4;
  localparam int DC   = 4;
  localparam int PW   = 2;
  localparam int DMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_pattern_gen_if #(.N_LEDS(N)) bus();

  led_pattern_gen #(
    .N_LEDS(N), .TICK_DIV(TD), .DEBOUNCE_CYCLES(DC), .PWM_W(PW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  // Pattern state is just "ticks since last mode change"; each mode's
  // display is a closed-form function of that count.
  bit          m_valid = 1'b0;
  int          m_mode, m_div, m_ticks, m_cyc;
  bit          m_us, m_ds;
  bit          hu [0:DC];   // hu[i] = raw up sampled i+1 edges ago
  bit          hd [0:DC];
  logic [N-1:0] m_led;
  bit          a1u, a0u, a1d, a0d, uev, dev;

  function automatic logic [N-1:0] pattern(int md, int tk, logic [N-1:0] s, int cyc);
    int p, d;
    logic [N-1:0] r;
    r = '0;
    case (md)
      0: r = tk[N-1:0];
      1: begin
        p = tk % (2*(N-1));
        if (p >= N) p = 2*(N-1) - p;
        r[p] = 1'b1;
      end
      2: r = s;
      default: begin
        d = tk % (2*DMAX);
        if (d > DMAX) d = 2*DMAX - d;
        r = ((cyc % (DMAX+1)) < d) ? s : '0;
      end
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_mode = 0; m_div = 0; m_ticks = 0; m_cyc = 0;
      m_us = 1'b0; m_ds = 1'b0; m_led = '0;
      for (int i = 0; i <= DC; i++) begin hu[i] = 1'b0; hd[i] = 1'b0; end
    end else if (m_valid) begin
      m_led = pattern(m_mode, m_ticks, bus.sw, m_cyc);
      // A level is accepted once the synchronised input (raw two edges back)
      // has shown it for DC consecutive edges.
      a1u = 1'b1; a0u = 1'b1; a1d = 1'b1; a0d = 1'b1;
      for (int i = 1; i <= DC; i++) begin
        if (hu[i]) a0u = 1'b0; else a1u = 1'b0;
        if (hd[i]) a0d = 1'b0; else a1d = 1'b0;
      end
      uev = !m_us && a1u;
      dev = !m_ds && a1d;
      if (a1u) m_us = 1'b1; else if (a0u) m_us = 1'b0;
      if (a1d) m_ds = 1'b1; else if (a0d) m_ds = 1'b0;
      for (int i = DC; i >= 1; i--) begin hu[i] = hu[i-1]; hd[i] = hd[i-1]; end
      hu[0] = bus.up;
      hd[0] = bus.down;
      if (uev != dev) begin
        m_mode  = uev ? (m_mode + 1) % 4 : (m_mode + 3) % 4;
        m_ticks = 0;
        m_div   = 0;
      end else if (m_div == TD-1) begin
        m_div = 0;
        m_ticks++;
      end else begin
        m_div++;
      end
      m_cyc++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      n_vec++;
      if (bus.LED !== m_led || bus.mode !== 2'(m_mode) || bus.tick !== (m_div == TD-1)) begin
        n_bad++;
        if (n_bad <= 20)
          $display("FAIL model t=%0t: LED=%h mode=%0d tick=%b, required LED=%h mode=%0d tick=%b",
                   $time, bus.LED, bus.mode, bus.tick, m_led, m_mode, (m_div == TD-1));
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tick !== 1'b1 && n < 2*TD);
    chk("tick_wait", bus.tick, 1);
  endtask

  task automatic press(input bit u, input bit d);
    bus.up = u; bus.down = d;
    repeat (8) @(negedge clk);
    bus.up = 1'b0; bus.down = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  int           bk [6] = '{1, 2, 3, 255, 256, 257};
  logic [7:0]   bv [6] = '{8'h01, 8'h02, 8'h03, 8'hFF, 8'h00, 8'h01};
  logic [7:0]   sexp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                              8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  int           dexp [7] = '{1, 2, 3, 2, 1, 0, 1};

  initial begin
    int cnt;
    logic [3:0] hi;
    bit found;
    reset = 1'b1; bus.sw = '0; bus.up = 1'b0; bus.down = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_led", bus.LED, 0);
    chk("rst_mode", bus.mode, 0);
    chk("rst_tick", bus.tick, 0);
    reset = 1'b0;

    // BINARY, including wrap after 256 ticks
    for (int k = 1; k <= 258; k++) begin
      wait_tick();
      repeat (2) @(negedge clk);
      for (int j = 0; j < 6; j++)
        if (k == bk[j]) chk("bin_led", bus.LED, bv[j]);
    end

    // reset mid-count
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_led", bus.LED, 0);
    chk("midrst_mode", bus.mode, 0);
    reset = 1'b0;

    // up held from edge 0: mode steps on edge 5
    bus.up = 1'b1;
    repeat (5) @(negedge clk);
    chk("up_pre", bus.mode, 0);
    @(negedge clk);
    chk("up_edge5", bus.mode, 1);
    @(negedge clk);
    chk("scan_start", bus.LED, 8'h01);
    bus.up = 1'b0;

    for (int k = 0; k < 15; k++) begin
      wait_tick();
      repeat (2) @(negedge clk);
      chk("scan_seq", bus.LED, sexp[k]);
    end

    // 3-cycle pulse is rejected
    bus.up = 1'b1;
    repeat (3) @(negedge clk);
    bus.up = 1'b0;
    repeat (8) @(negedge clk);
    chk("pulse3_mode", bus.mode, 1);

    // mode change mid-pattern at pos 5
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.LED === 8'h20) found = 1'b1;
    end
    chk("scan_pos5", bus.LED, 8'h20);
    press(1'b1, 1'b0);
    chk("to_mirror", bus.mode, 2);
    bus.down = 1'b1;
    repeat (5) @(negedge clk);
    chk("dn_pre", bus.mode, 2);
    @(negedge clk);
    chk("dn_edge5", bus.mode, 1);
    @(negedge clk);
    chk("scan_clr", bus.LED, 8'h01);
    chk("tick_clr", bus.tick, 0);
    repeat (2) @(negedge clk);
    chk("tick_restart", bus.tick, 1);
    repeat (2) @(negedge clk);
    chk("scan_after", bus.LED, 8'h02);
    bus.down = 1'b0;
    repeat (8) @(negedge clk);

    // simultaneous presses cancel
    press(1'b1, 1'b1);
    chk("both_mode", bus.mode, 1);

    // down wraps 0 -> 3
    press(1'b0, 1'b1);
    chk("dn_to0", bus.mode, 0);
    press(1'b0, 1'b1);
    chk("dn_wrap", bus.mode, 3);

    // MIRROR
    press(1'b0, 1'b1);
    chk("mirror_mode", bus.mode, 2);
    bus.sw = 8'hA5;
    @(negedge clk);
    chk("mirror_a5", bus.LED, 8'hA5);
    bus.sw = 8'h3C;
    @(negedge clk);
    chk("mirror_3c", bus.LED, 8'h3C);

    // BREATHE
    bus.sw = 8'h0F;
    bus.up = 1'b1;
    repeat (6) @(negedge clk);
    chk("breathe_mode", bus.mode, 3);
    @(negedge clk);
    chk("breathe_d0a", bus.LED, 0);
    @(negedge clk);
    chk("breathe_d0b", bus.LED, 0);
    bus.up = 1'b0;
    wait_tick();
    @(negedge clk);
    for (int j = 0; j < 7; j++) begin
      cnt = 0; hi = '0;
      repeat (4) begin
        @(negedge clk);
        if (bus.LED[3:0] === 4'hF) cnt++;
        hi = hi | bus.LED[7:4];
      end
      chk("breathe_duty", cnt, dexp[j]);
      chk("breathe_hi", hi, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end
endmodule
